// File: rtl/bist_pkg.sv
// Shared types and constants for the ALU BIST engine: state encoding,
// LFSR/MISR widths and feedback tap masks.
package bist_pkg;

    localparam int PAT_W = 34;
    localparam int SIG_W = 17;

    // Feedback masks: LFSR taps 34,27,2,1 and MISR polynomial x^17+x^14+1.
    localparam logic [PAT_W-1:0] LFSR_TAPS = 34'h2_0400_0003;
    localparam logic [SIG_W-1:0] MISR_TAPS = 17'h1_2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] v);
        return {v[PAT_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 17-bit multiple-input signature register compacting {cout, result}.
module bist_misr
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);

    logic [SIG_W-1:0] sig_q;

    assign sig_next = {sig_q[SIG_W-2:0], ^(sig_q & MISR_TAPS)} ^ din;
    assign sig      = sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_next;
        end
    end

endmodule

// File: rtl/alu_bist_engine.sv
// ALU BIST engine: LFSR pattern source, latency-aligned MISR capture, golden compare.
//   state    | meaning
//   ST_IDLE  | waiting for start, nothing driven since reset
//   ST_RUN   | issuing one LFSR pattern per cycle
//   ST_DRAIN | patterns done, waiting RESP_LATENCY cycles for last responses
//   ST_DONE  | signature and pass held until the next start
module alu_bist_engine
    import bist_pkg::*;
#(
    parameter int unsigned      NUM_PATTERNS = 1024,
    parameter int unsigned      RESP_LATENCY = 0,
    parameter logic [PAT_W-1:0] SEED         = 34'h2_AAAA_5555,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 17'h0_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [1:0]       alu_sel,
    input  logic [15:0]      alu_result,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      pattern_cnt
);

    if (SEED == '0) begin : g_bad_seed
        $error("alu_bist_engine: SEED must be nonzero");
    end
    if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_num
        $error("alu_bist_engine: NUM_PATTERNS out of range 1..65535");
    end
    if (RESP_LATENCY > 3) begin : g_bad_lat
        $error("alu_bist_engine: RESP_LATENCY out of range 0..3");
    end

    localparam logic [3:0] LAT_SEL = 4'b0001 << RESP_LATENCY;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] lfsr_q;
    logic [15:0]      cnt_q;
    logic [1:0]       drain_q;
    logic [2:0]       vld_sr;
    logic [3:0]       vld_tap;
    logic             pass_q;
    logic             start_ok, run_c, last_pat, drain_tc, done_entry, cap_en;
    logic [SIG_W-1:0] misr_next;

    assign run_c      = (state_q == ST_RUN);
    assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_pat   = run_c && (cnt_q == 16'(NUM_PATTERNS - 1));
    assign drain_tc   = (state_q == ST_DRAIN) && (drain_q == 2'd0);
    assign done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Tap 0 is the live RUN flag; tap n is that flag delayed n cycles.
    assign vld_tap = {vld_sr, run_c};
    assign cap_en  = |(vld_tap & LAT_SEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (last_pat) state_d = (RESP_LATENCY > 0) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: if (drain_tc) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN, ST_DRAIN: busy = 1'b1;
            ST_DONE:          done = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            vld_sr  <= '0;
            pass_q  <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[1:0], run_c};
            if (start_ok) begin
                lfsr_q <= SEED;
                cnt_q  <= '0;
                pass_q <= 1'b0;
            end else if (run_c) begin
                lfsr_q <= lfsr_step(lfsr_q);
                cnt_q  <= cnt_q + 16'd1;
            end
            if (last_pat) begin
                drain_q <= 2'(RESP_LATENCY - 1);
            end else if (state_q == ST_DRAIN) begin
                drain_q <= drain_q - 2'd1;
            end
            // Final capture lands on this same edge, so compare the MISR's next value.
            if (done_entry) begin
                pass_q <= (misr_next == GOLDEN_SIG);
            end
        end
    end

    bist_misr u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .en       (cap_en),
        .din      ({alu_cout, alu_result}),
        .sig      (signature),
        .sig_next (misr_next)
    );

    assign alu_a       = lfsr_q[33:18];
    assign alu_b       = lfsr_q[17:2];
    assign alu_sel     = lfsr_q[1:0];
    assign pattern_cnt = cnt_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_alu_bist_engine.sv
// Bench for alu_bist_engine: three instances (combinational ALU with fault mask,
// 2-stage ALU with matching latency, 2-stage ALU with mismatched latency).
module tb_alu_bist_engine;

    localparam logic [33:0] SEED = 34'h2_AAAA_5555;
    localparam int          NP   = 16;

    // Reference ALU: 0 add, 1 subtract (a + ~b + 1), 2 and, 3 xor.
    function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // Signature after n patterns from seed, with result bits in fm forced to 0.
    function automatic logic [16:0] model_sig(input logic [33:0] seed, input int n,
                                              input logic [15:0] fm);
        logic [33:0] l;
        logic [16:0] s;
        logic [16:0] r;
        l = seed;
        s = '0;
        for (int i = 0; i < n; i++) begin
            r = alu_ref(l[33:18], l[17:2], l[1:0]);
            r[15:0] = r[15:0] & ~fm;
            s = {s[15:0], s[16] ^ s[13]} ^ r;
            l = {l[32:0], l[33] ^ l[26] ^ l[1] ^ l[0]};
        end
        return s;
    endfunction

    localparam logic [16:0] GOLDEN = model_sig(SEED, NP, 16'h0000);

    typedef struct {
        int          d;
        logic [15:0] fm;
        int          done_cyc;
        logic        exp_pass;
        logic        sig_known;
        logic [16:0] exp_sig;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];
    logic [1:0]  sel_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        pass_v  [3];
    logic [16:0] sig_v   [3];
    logic [15:0] cnt_v   [3];
    logic [15:0] res0, res1, res2;
    logic        cout0, cout1, cout2;
    logic [15:0] fmask;
    logic [16:0] r0c, r1c, r2c, p1a, p1b, p2a, p2b;
    logic [33:0] exp_pat [NP+1];
    vec_t        tbl     [4];
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    always_comb begin
        r0c   = alu_ref(a_v[0], b_v[0], sel_v[0]);
        res0  = r0c[15:0] & ~fmask;
        cout0 = r0c[16];
        r1c   = alu_ref(a_v[1], b_v[1], sel_v[1]);
        r2c   = alu_ref(a_v[2], b_v[2], sel_v[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1a <= '0; p1b <= '0; p2a <= '0; p2b <= '0;
        end else begin
            p1a <= r1c; p1b <= p1a; p2a <= r2c; p2b <= p2a;
        end
    end
    assign res1 = p1b[15:0];
    assign cout1 = p1b[16];
    assign res2 = p2b[15:0];
    assign cout2 = p2b[16];

    alu_bist_engine #(.NUM_PATTERNS(NP), .RESP_LATENCY(0), .SEED(SEED), .GOLDEN_SIG(GOLDEN)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .alu_a(a_v[0]), .alu_b(b_v[0]), .alu_sel(sel_v[0]),
        .alu_result(res0), .alu_cout(cout0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .signature(sig_v[0]), .pattern_cnt(cnt_v[0]));

    alu_bist_engine #(.NUM_PATTERNS(NP), .RESP_LATENCY(2), .SEED(SEED), .GOLDEN_SIG(GOLDEN)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .alu_a(a_v[1]), .alu_b(b_v[1]), .alu_sel(sel_v[1]),
        .alu_result(res1), .alu_cout(cout1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .signature(sig_v[1]), .pattern_cnt(cnt_v[1]));

    alu_bist_engine #(.NUM_PATTERNS(NP), .RESP_LATENCY(0), .SEED(SEED), .GOLDEN_SIG(GOLDEN)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .alu_a(a_v[2]), .alu_b(b_v[2]), .alu_sel(sel_v[2]),
        .alu_result(res2), .alu_cout(cout2),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .signature(sig_v[2]), .pattern_cnt(cnt_v[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Start instance d, follow it cycle by cycle to done_cyc, optionally pulse start at cycle ign.
    task automatic run(input int d, input int done_cyc, input int ign,
                       output logic [16:0] sig_o, output logic pass_o);
        int lag;
        int nc;
        lag = (d == 1) ? 2 : 0;
        start_v[d] = 1'b1;
        for (int c = 0; c <= done_cyc; c++) begin
            next_cycle();
            start_v[d] = 1'b0;
            chk("busy", 64'(busy_v[d]), 64'(c < done_cyc));
            chk("done", 64'(done_v[d]), 64'(c == done_cyc));
            chk("pattern_cnt", 64'(cnt_v[d]), 64'((c < NP) ? c : NP));
            if (c < NP) chk("pattern", 64'({a_v[d], b_v[d], sel_v[d]}), 64'(exp_pat[c]));
            if (d != 2) begin
                nc = c - lag;
                if (nc < 0) nc = 0;
                if (nc > NP) nc = NP;
                chk("signature", 64'(sig_v[d]),
                    64'(model_sig(SEED, nc, (d == 0) ? fmask : 16'h0000)));
            end
            if (c == ign) start_v[d] = 1'b1;
        end
        sig_o  = sig_v[d];
        pass_o = pass_v[d];
    endtask

    initial begin
        logic [33:0] l;
        logic [16:0] s_o;
        logic        p_o;
        logic [16:0] esig;
        int          gap;
        int          bit_i;

        l = SEED;
        for (int k = 0; k <= NP; k++) begin
            exp_pat[k] = l;
            l = {l[32:0], l[33] ^ l[26] ^ l[1] ^ l[0]};
        end
        tbl[0] = '{0, 16'h0000, 16, 1'b1, 1'b1, GOLDEN};
        tbl[1] = '{0, 16'h0080, 16, 1'b0, 1'b1, model_sig(SEED, NP, 16'h0080)};
        tbl[2] = '{1, 16'h0000, 18, 1'b1, 1'b1, GOLDEN};
        tbl[3] = '{2, 16'h0000, 16, 1'b0, 1'b0, GOLDEN};

        rst_n = 1'b0;
        fmask = 16'h0000;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

        // Reset values, then start held high across release.
        repeat (2) next_cycle();
        chk("rst_outputs", 64'({a_v[0], b_v[0], sel_v[0], busy_v[0], done_v[0], pass_v[0]}), 64'h0);
        chk("rst_sig", 64'(sig_v[0]), 64'h0);
        chk("rst_cnt", 64'(cnt_v[0]), 64'h0);
        start_v[0] = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        next_cycle();
        start_v[0] = 1'b0;
        chk("first_busy", 64'(busy_v[0]), 64'h1);
        chk("first_a", 64'(a_v[0]), 64'hAAAA);
        chk("first_b", 64'(b_v[0]), 64'h9555);
        chk("first_sel", 64'(sel_v[0]), 64'h1);
        repeat (5) next_cycle();
        chk("mid_cnt", 64'(cnt_v[0]), 64'h5);
        chk("mid_sig", 64'(sig_v[0]), 64'(model_sig(SEED, 5, 16'h0000)));

        // Asynchronous reset mid-cycle with start asserted.
        start_v[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy_v[0]), 64'h0);
        chk("async_cnt", 64'(cnt_v[0]), 64'h0);
        chk("async_sig", 64'(sig_v[0]), 64'h0);
        chk("async_pat", 64'({a_v[0], b_v[0], sel_v[0]}), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        next_cycle();
        start_v[0] = 1'b0;
        chk("restart_busy", 64'(busy_v[0]), 64'h1);
        chk("restart_cnt", 64'(cnt_v[0]), 64'h0);
        chk("restart_a", 64'(a_v[0]), 64'hAAAA);
        repeat (NP) next_cycle();
        chk("fresh_done", 64'(done_v[0]), 64'h1);
        chk("fresh_pass", 64'(pass_v[0]), 64'h1);
        chk("fresh_sig", 64'(sig_v[0]), 64'(GOLDEN));

        for (int t = 0; t < 4; t++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) next_cycle();
            fmask = tbl[t].fm;
            run(tbl[t].d, tbl[t].done_cyc, -1, s_o, p_o);
            chk("tbl_pass", 64'(p_o), 64'(tbl[t].exp_pass));
            if (tbl[t].sig_known) chk("tbl_sig", 64'(s_o), 64'(tbl[t].exp_sig));
            else chk("tbl_sig_ne_golden", 64'(s_o == GOLDEN), 64'h0);
        end

        // Ignored start pulses in RUN; second run launched directly from DONE.
        fmask = 16'h0000;
        run(0, NP, 5, s_o, p_o);
        chk("ign5_pass", 64'(p_o), 64'h1);
        chk("ign5_sig", 64'(s_o), 64'(GOLDEN));
        run(0, NP, $urandom_range(1, 14), s_o, p_o);
        chk("rerun_pass", 64'(p_o), 64'h1);
        chk("rerun_sig", 64'(s_o), 64'(GOLDEN));

        for (int i = 0; i < 3; i++) begin
            bit_i = $urandom_range(0, 15);
            fmask = 16'h0001 << bit_i;
            esig  = model_sig(SEED, NP, fmask);
            gap   = $urandom_range(0, 2);
            repeat (gap) next_cycle();
            run(0, NP, -1, s_o, p_o);
            chk("rand_fault_sig", 64'(s_o), 64'(esig));
            chk("rand_fault_pass", 64'(p_o), 64'(esig == GOLDEN));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
